// File: rtl/id_hazard_scoreboard_if.sv
// rtl/id_hazard_scoreboard_if.sv - ID-stage hazard scoreboard signal bundle
interface id_hazard_scoreboard_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             i_id_valid;
    logic [REG_W-1:0] i_id_rs;
    logic [REG_W-1:0] i_id_rt;
    logic [REG_W-1:0] i_id_rd;
    logic             i_id_uses_rs;
    logic             i_id_uses_rt;
    logic             i_dest_sel;
    logic             i_reg_write;
    logic             i_mem_read;
    logic             i_flush;
    logic             i_hold;
    logic             o_stall;
    logic [REG_W-1:0] o_ex_dest;
    logic [1:0]       o_fwd_rs_sel;
    logic [1:0]       o_fwd_rt_sel;
    logic [CNT_W-1:0] o_stall_cycles;

    modport master (
        output i_id_valid, i_id_rs, i_id_rt, i_id_rd, i_id_uses_rs, i_id_uses_rt,
               i_dest_sel, i_reg_write, i_mem_read, i_flush, i_hold,
        input  o_stall, o_ex_dest, o_fwd_rs_sel, o_fwd_rt_sel, o_stall_cycles
    );

    modport slave (
        input  i_id_valid, i_id_rs, i_id_rt, i_id_rd, i_id_uses_rs, i_id_uses_rt,
               i_dest_sel, i_reg_write, i_mem_read, i_flush, i_hold,
        output o_stall, o_ex_dest, o_fwd_rs_sel, o_fwd_rt_sel, o_stall_cycles
    );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - decode-stage hazard stall and forwarding-select scoreboard
// Optional FORWARDING_EN: load-use-only stalls with registered EX forwarding selects.
module id_hazard_scoreboard #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input logic                   i_clk,
    input logic                   i_reset,
    id_hazard_scoreboard_if.slave bus
);
    logic [REG_W-1:0] id_dest;
    logic             id_writes;
    logic             ex_valid;
    logic [REG_W-1:0] ex_dest;
    logic             mem_valid;
    logic [REG_W-1:0] mem_dest;
    logic             rs_ex, rt_ex, rs_mem, rt_mem;
    logic             stall;
    logic             accept;
    logic [CNT_W-1:0] stall_cnt;

    // Same RT/RD choice as the datapath destination mux.
    assign id_dest   = bus.i_dest_sel ? bus.i_id_rt : bus.i_id_rd;
    assign id_writes = bus.i_id_valid && bus.i_reg_write && (id_dest != '0);

    assign rs_ex  = bus.i_id_uses_rs && (bus.i_id_rs != '0) && ex_valid  && (ex_dest  == bus.i_id_rs);
    assign rt_ex  = bus.i_id_uses_rt && (bus.i_id_rt != '0) && ex_valid  && (ex_dest  == bus.i_id_rt);
    assign rs_mem = bus.i_id_uses_rs && (bus.i_id_rs != '0) && mem_valid && (mem_dest == bus.i_id_rs);
    assign rt_mem = bus.i_id_uses_rt && (bus.i_id_rt != '0) && mem_valid && (mem_dest == bus.i_id_rt);

`ifdef FORWARDING_EN
    logic       ex_load;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    assign stall = bus.i_id_valid && !bus.i_flush && (rs_ex || rt_ex) && ex_load;
`else
    logic unused_mem_read;

    assign unused_mem_read = bus.i_mem_read;
    assign stall = bus.i_id_valid && !bus.i_flush && (rs_ex || rt_ex || rs_mem || rt_mem);
`endif

    assign accept = bus.i_id_valid && !stall && !bus.i_flush;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_valid  <= 1'b0;
            ex_dest   <= '0;
            mem_valid <= 1'b0;
            mem_dest  <= '0;
            stall_cnt <= '0;
`ifdef FORWARDING_EN
            ex_load    <= 1'b0;
            fwd_rs_sel <= 2'b00;
            fwd_rt_sel <= 2'b00;
`endif
        end else begin
            if (!bus.i_hold) begin
                mem_valid <= ex_valid;
                mem_dest  <= ex_dest;
                if (accept) begin
                    ex_valid <= id_writes;
                    ex_dest  <= id_dest;
`ifdef FORWARDING_EN
                    ex_load    <= bus.i_mem_read;
                    // EX producer is younger, so it wins over MEM.
                    fwd_rs_sel <= rs_ex ? 2'b01 : (rs_mem ? 2'b10 : 2'b00);
                    fwd_rt_sel <= rt_ex ? 2'b01 : (rt_mem ? 2'b10 : 2'b00);
`endif
                end else begin
                    ex_valid <= 1'b0;
                    ex_dest  <= '0;
`ifdef FORWARDING_EN
                    ex_load    <= 1'b0;
                    fwd_rs_sel <= 2'b00;
                    fwd_rt_sel <= 2'b00;
`endif
                end
            end
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign bus.o_stall        = stall;
    assign bus.o_ex_dest      = ex_dest;
    assign bus.o_stall_cycles = stall_cnt;
`ifdef FORWARDING_EN
    assign bus.o_fwd_rs_sel = fwd_rs_sel;
    assign bus.o_fwd_rt_sel = fwd_rt_sel;
`else
    assign bus.o_fwd_rs_sel = 2'b00;
    assign bus.o_fwd_rt_sel = 2'b00;
`endif
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - directed self-checking bench for id_hazard_scoreboard
module tb_id_hazard_scoreboard;
    logic i_clk = 1'b0;
    logic i_reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;

    id_hazard_scoreboard_if #(.REG_W(5), .CNT_W(16)) bus ();

    id_hazard_scoreboard #(.REG_W(5), .CNT_W(16)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // valid, rs, rt, rd, uses_rs, uses_rt, dest_sel, reg_write, mem_read
    task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic urs, input logic urt, input logic dsel, input logic rw, input logic mr);
        bus.i_id_valid   = v;
        bus.i_id_rs      = rs;
        bus.i_id_rt      = rt;
        bus.i_id_rd      = rd;
        bus.i_id_uses_rs = urs;
        bus.i_id_uses_rt = urt;
        bus.i_dest_sel   = dsel;
        bus.i_reg_write  = rw;
        bus.i_mem_read   = mr;
        #1;
    endtask

    task automatic idle();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nop();
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        tick();
        tick();
    endtask

    initial begin
        i_reset     = 1'b1;
        bus.i_flush = 1'b0;
        bus.i_hold  = 1'b0;
        idle();
        tick();
        tick();
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_eq("rst_stall", 32'(bus.o_stall), 32'd0);
        check_eq("rst_rs_sel", 32'(bus.o_fwd_rs_sel), 32'd0);
        check_eq("rst_rt_sel", 32'(bus.o_fwd_rt_sel), 32'd0);
        check_eq("rst_ex_dest", 32'(bus.o_ex_dest), 32'd0);
        check_eq("rst_cnt", 32'(bus.o_stall_cycles), 32'd0);

        // add $3 then sub reading $3 back-to-back
        issue(1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 1, 0);
        check_eq("add3_stall", 32'(bus.o_stall), 32'd0);
        tick();
        check_eq("add3_ex_dest", 32'(bus.o_ex_dest), 32'd3);
        issue(1, 5'd3, 5'd4, 5'd8, 1, 1, 0, 1, 0);
`ifdef FORWARDING_EN
        check_eq("sub_stall", 32'(bus.o_stall), 32'd0);
        tick();
        check_eq("sub_rs_sel", 32'(bus.o_fwd_rs_sel), 32'd1);
        check_eq("sub_rt_sel", 32'(bus.o_fwd_rt_sel), 32'd0);
`else
        check_eq("sub_stall_c1", 32'(bus.o_stall), 32'd1);
        tick();
        check_eq("sub_bubble", 32'(bus.o_ex_dest), 32'd0);
        check_eq("sub_stall_c2", 32'(bus.o_stall), 32'd1);
        tick();
        check_eq("sub_stall_c3", 32'(bus.o_stall), 32'd0);
        tick();
        check_eq("sub_rs_sel", 32'(bus.o_fwd_rs_sel), 32'd0);
        exp_cnt += 2;
`endif
        check_eq("sub_ex_dest", 32'(bus.o_ex_dest), 32'd8);
        drain();
        check_eq("cnt_after_sub", 32'(bus.o_stall_cycles), 32'(exp_cnt));

        // lw $5 then add reading rt = $5
        issue(1, 5'd1, 5'd5, 5'd0, 1, 0, 1, 1, 1);
        tick();
        check_eq("lw_ex_dest", 32'(bus.o_ex_dest), 32'd5);
        issue(1, 5'd6, 5'd5, 5'd9, 1, 1, 0, 1, 0);
        check_eq("lu_stall_c1", 32'(bus.o_stall), 32'd1);
        tick();
        check_eq("lu_bubble", 32'(bus.o_ex_dest), 32'd0);
`ifdef FORWARDING_EN
        exp_cnt += 1;
`else
        check_eq("lu_stall_c2", 32'(bus.o_stall), 32'd1);
        tick();
        exp_cnt += 2;
`endif
        check_eq("lu_stall_end", 32'(bus.o_stall), 32'd0);
        tick();
        check_eq("lu_ex_dest", 32'(bus.o_ex_dest), 32'd9);
`ifdef FORWARDING_EN
        check_eq("lu_rt_sel", 32'(bus.o_fwd_rt_sel), 32'd2);
`else
        check_eq("lu_rt_sel", 32'(bus.o_fwd_rt_sel), 32'd0);
`endif
        check_eq("lu_rs_sel", 32'(bus.o_fwd_rs_sel), 32'd0);
        check_eq("lu_cnt", 32'(bus.o_stall_cycles), 32'(exp_cnt));
        drain();

        // add $7, one unrelated instruction, then reader of $7
        issue(1, 5'd1, 5'd2, 5'd7, 1, 1, 0, 1, 0);
        tick();
        nop();
        tick();
        issue(1, 5'd7, 5'd0, 5'd10, 1, 0, 0, 1, 0);
`ifdef FORWARDING_EN
        check_eq("d2_stall", 32'(bus.o_stall), 32'd0);
        tick();
        check_eq("d2_rs_sel", 32'(bus.o_fwd_rs_sel), 32'd2);
`else
        check_eq("d2_stall_c1", 32'(bus.o_stall), 32'd1);
        tick();
        check_eq("d2_stall_c2", 32'(bus.o_stall), 32'd0);
        exp_cnt += 1;
        tick();
`endif
        check_eq("d2_ex_dest", 32'(bus.o_ex_dest), 32'd10);
        drain();

        // add $7, two unrelated instructions, then reader: producer already in WB
        issue(1, 5'd1, 5'd2, 5'd7, 1, 1, 0, 1, 0);
        tick();
        nop();
        tick();
        tick();
        issue(1, 5'd7, 5'd0, 5'd11, 1, 0, 0, 1, 0);
        check_eq("d3_stall", 32'(bus.o_stall), 32'd0);
        tick();
        check_eq("d3_rs_sel", 32'(bus.o_fwd_rs_sel), 32'd0);
        drain();

        // writer to $0 then reader of $0
        issue(1, 5'd1, 5'd2, 5'd0, 1, 1, 0, 1, 1);
        tick();
        issue(1, 5'd0, 5'd0, 5'd12, 1, 1, 0, 1, 0);
        check_eq("r0_stall", 32'(bus.o_stall), 32'd0);
        tick();
        check_eq("r0_rs_sel", 32'(bus.o_fwd_rs_sel), 32'd0);
        check_eq("r0_rt_sel", 32'(bus.o_fwd_rt_sel), 32'd0);
        drain();

        // load-use with flush in the same cycle
        issue(1, 5'd1, 5'd5, 5'd0, 1, 0, 1, 1, 1);
        tick();
        issue(1, 5'd6, 5'd5, 5'd9, 1, 1, 0, 1, 0);
        bus.i_flush = 1'b1;
        #1;
        check_eq("fl_stall", 32'(bus.o_stall), 32'd0);
        tick();
        check_eq("fl_bubble", 32'(bus.o_ex_dest), 32'd0);
        bus.i_flush = 1'b0;
        drain();
        check_eq("fl_cnt", 32'(bus.o_stall_cycles), 32'(exp_cnt));

        // load-use frozen by hold for two cycles
        issue(1, 5'd1, 5'd5, 5'd0, 1, 0, 1, 1, 1);
        tick();
        issue(1, 5'd6, 5'd5, 5'd9, 1, 1, 0, 1, 0);
        bus.i_hold = 1'b1;
        #1;
        check_eq("hd_stall_c0", 32'(bus.o_stall), 32'd1);
        tick();
        tick();
        exp_cnt += 2;
        check_eq("hd_stall_c2", 32'(bus.o_stall), 32'd1);
        check_eq("hd_frozen_dest", 32'(bus.o_ex_dest), 32'd5);
        check_eq("hd_cnt", 32'(bus.o_stall_cycles), 32'(exp_cnt));
        bus.i_hold = 1'b0;
        #1;
        tick();
        exp_cnt += 1;
        check_eq("hd_bubble", 32'(bus.o_ex_dest), 32'd0);
`ifndef FORWARDING_EN
        check_eq("hd_stall_mem", 32'(bus.o_stall), 32'd1);
        tick();
        exp_cnt += 1;
`endif
        check_eq("hd_stall_end", 32'(bus.o_stall), 32'd0);
        tick();
        check_eq("hd_ex_dest", 32'(bus.o_ex_dest), 32'd9);
        check_eq("hd_cnt_end", 32'(bus.o_stall_cycles), 32'(exp_cnt));
        drain();

        // reset asserted while stalled
        issue(1, 5'd1, 5'd5, 5'd0, 1, 0, 1, 1, 1);
        tick();
        issue(1, 5'd6, 5'd5, 5'd9, 1, 1, 0, 1, 0);
        check_eq("rs_stall_pre", 32'(bus.o_stall), 32'd1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_eq("rs_stall_post", 32'(bus.o_stall), 32'd0);
        check_eq("rs_ex_dest", 32'(bus.o_ex_dest), 32'd0);
        check_eq("rs_cnt", 32'(bus.o_stall_cycles), 32'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
